ras_ctrl: RTL and testbench

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/ras_ctrl.sv | 98 +++++++++
 tb/tb_ras_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// ras_ctrl: speculative return-address-stack controller with a STAGES-deep in-flight op pipeline
//
// Parameters: STAGES (speculative stages, >=1), WIDTH (return-address width, halfword units)
// Ports:
//   clk, rst_ni                          clock, asynchronous active-low reset
//   fe_valid_i/fe_ready_o                fetch op handshake
//   fe_call_i, fe_ret_i, fe_pc_i, fe_rvc_i  op kind, halfword PC, 16-bit instruction flag
//   be_retire_valid_i/be_retire_ready_o  retire of the op in the last stage
//   be_mispredict_i                      discard all non-retired ops
//   ras_push_o, ras_pop_o, ras_din_o     stack push/pop strobes and pushed return address
//   ras_commit_o, ras_flush_o            per-stage advance / discard strobes
//   ras_dout_i, ras_valid_i              top-of-stack value and its validity
//   pred_valid_o, pred_target_o          registered return prediction
//   stat_mispred_o, stat_underflow_o     saturating event counters (only with RAS_CTRL_STATS_EN)
// rst_ni is expected to be deasserted synchronously to clk by its source.
module ras_ctrl #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 31
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              fe_valid_i,
   output logic              fe_ready_o,
   input  logic              fe_call_i,
   input  logic              fe_ret_i,
   input  logic [WIDTH-1:0]  fe_pc_i,
   input  logic              fe_rvc_i,
   input  logic              be_retire_valid_i,
   output logic              be_retire_ready_o,
   input  logic              be_mispredict_i,
   output logic              ras_push_o,
   output logic              ras_pop_o,
   output logic [WIDTH-1:0]  ras_din_o,
   output logic [STAGES-1:0] ras_commit_o,
   output logic [STAGES-1:0] ras_flush_o,
   input  logic [WIDTH-1:0]  ras_dout_i,
   input  logic              ras_valid_i,
   output logic              pred_valid_o,
   output logic [WIDTH-1:0]  pred_target_o,
   output logic [31:0]       stat_mispred_o,
   output logic [31:0]       stat_underflow_o
);
   localparam logic [STAGES-1:0] TOP = STAGES'(1) << (STAGES-1);
   logic [STAGES-1:0] r_occ;
   logic [STAGES-1:0] w_adv;
   logic [STAGES-1:0] w_occ_nxt;
   logic              w_accept;
   logic [WIDTH-1:0]  r_pred_target;
   logic              r_pred_valid;
   // A stage advances when the stage above is empty or itself advancing this cycle.
   always_comb begin
      w_adv = '0;
      w_adv[STAGES-1] = r_occ[STAGES-1] & be_retire_valid_i;
      for (int i = STAGES-2; i >= 0; i--) w_adv[i] = r_occ[i] & (~r_occ[i+1] | w_adv[i+1]);
   end
   // On mispredict only a retiring last-stage op survives; everything else is flushed.
   assign ras_commit_o      = be_mispredict_i ? (w_adv & TOP) : w_adv;
   assign ras_flush_o       = be_mispredict_i ? (r_occ & ~ras_commit_o) : '0;
   assign fe_ready_o        = ~be_mispredict_i & (~r_occ[0] | ras_commit_o[0]);
   assign be_retire_ready_o = r_occ[STAGES-1];
   assign w_accept          = fe_valid_i & fe_ready_o & (fe_call_i | fe_ret_i);
   assign ras_push_o        = w_accept & fe_call_i;
   assign ras_pop_o         = w_accept & fe_ret_i;
   assign ras_din_o         = fe_pc_i + (fe_rvc_i ? WIDTH'(1) : WIDTH'(2));
   assign w_occ_nxt         = be_mispredict_i ? '0 :
                              (r_occ & ~ras_commit_o) | (ras_commit_o << 1) | STAGES'(w_accept);
   assign pred_valid_o      = r_pred_valid;
   assign pred_target_o     = r_pred_target;
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_occ         <= '0;
         r_pred_valid  <= 1'b0;
         r_pred_target <= '0;
      end else begin
         r_occ        <= w_occ_nxt;
         r_pred_valid <= ras_pop_o & ras_valid_i;
         if (ras_pop_o) r_pred_target <= ras_dout_i;
      end
   end
`ifdef RAS_CTRL_STATS_EN
   logic [31:0] r_mispred;
   logic [31:0] r_underflow;
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mispred   <= '0;
         r_underflow <= '0;
      end else begin
         if (be_mispredict_i && |r_occ && ~&r_mispred) r_mispred <= r_mispred + 32'd1;
         if (ras_pop_o && !ras_valid_i && ~&r_underflow) r_underflow <= r_underflow + 32'd1;
      end
   end
   assign stat_mispred_o   = r_mispred;
   assign stat_underflow_o = r_underflow;
`else
   assign stat_mispred_o   = '0;
   assign stat_underflow_o = '0;
`endif
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: scoreboard bench for ras_ctrl against an op-list reference model
module tb_ras_ctrl;
   localparam int S = 2;
   localparam int W = 31;
   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic fe_valid_i = 1'b0, fe_call_i = 1'b0, fe_ret_i = 1'b0, fe_rvc_i = 1'b0;
   logic [W-1:0] fe_pc_i = '0, ras_dout_i = '0;
   logic be_retire_valid_i = 1'b0, be_mispredict_i = 1'b0, ras_valid_i = 1'b0;
   logic fe_ready_o, be_retire_ready_o, ras_push_o, ras_pop_o, pred_valid_o;
   logic [W-1:0] ras_din_o, pred_target_o;
   logic [S-1:0] ras_commit_o, ras_flush_o;
   logic [31:0] stat_mispred_o, stat_underflow_o;
   ras_ctrl #(.STAGES(S), .WIDTH(W)) dut (
      .clk(clk), .rst_ni(rst_ni),
      .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o),
      .fe_call_i(fe_call_i), .fe_ret_i(fe_ret_i), .fe_pc_i(fe_pc_i), .fe_rvc_i(fe_rvc_i),
      .be_retire_valid_i(be_retire_valid_i), .be_retire_ready_o(be_retire_ready_o),
      .be_mispredict_i(be_mispredict_i),
      .ras_push_o(ras_push_o), .ras_pop_o(ras_pop_o), .ras_din_o(ras_din_o),
      .ras_commit_o(ras_commit_o), .ras_flush_o(ras_flush_o),
      .ras_dout_i(ras_dout_i), .ras_valid_i(ras_valid_i),
      .pred_valid_o(pred_valid_o), .pred_target_o(pred_target_o),
      .stat_mispred_o(stat_mispred_o), .stat_underflow_o(stat_underflow_o)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic rdy, rr, push, pop, pv;
      logic [W-1:0] din, pt;
      logic [S-1:0] cm, fl;
      logic [31:0] sm, su;
   } exp_t;
   exp_t sb[$];
   int n_tests = 0;
   int n_fail = 0;
   // Reference model: in-flight ops as a list of stage positions, oldest first.
   int q[$];
   logic m_pv = 1'b0;
   logic [W-1:0] m_pt = '0;
   logic [31:0] m_sm = '0, m_su = '0;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      n_tests++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
      end
   endtask
   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("fe_ready", 64'(fe_ready_o), 64'(e.rdy));
         chk("retire_ready", 64'(be_retire_ready_o), 64'(e.rr));
         chk("push", 64'(ras_push_o), 64'(e.push));
         chk("pop", 64'(ras_pop_o), 64'(e.pop));
         if (e.push) chk("din", 64'(ras_din_o), 64'(e.din));
         chk("commit", 64'(ras_commit_o), 64'(e.cm));
         chk("flush", 64'(ras_flush_o), 64'(e.fl));
         chk("pred_valid", 64'(pred_valid_o), 64'(e.pv));
         chk("pred_target", 64'(pred_target_o), 64'(e.pt));
         chk("stat_mispred", 64'(stat_mispred_o), 64'(e.sm));
         chk("stat_underflow", 64'(stat_underflow_o), 64'(e.su));
      end
   end
   task automatic step(input logic v, c, r, input logic [W-1:0] pc, input logic rvc, rv, mp,
                       input logic [W-1:0] dout, input logic dv);
      exp_t e;
      int nq[$];
      int lim;
      logic [S-1:0] occm;
      logic acc;
      @(negedge clk);
      fe_valid_i = v; fe_call_i = c; fe_ret_i = r; fe_pc_i = pc; fe_rvc_i = rvc;
      be_retire_valid_i = rv; be_mispredict_i = mp; ras_dout_i = dout; ras_valid_i = dv;
      occm = '0;
      foreach (q[k]) occm[q[k]] = 1'b1;
      e.cm = '0;
      e.fl = '0;
      lim = S;
      if (mp) begin
         if (q.size() > 0 && q[0] == S-1 && rv) e.cm[S-1] = 1'b1;
         e.fl = occm & ~e.cm;
         lim = 0;
      end else begin
         foreach (q[k]) begin
            if (q[k] == S-1 && rv) e.cm[S-1] = 1'b1;
            else if (q[k] + 1 < lim) begin
               e.cm[q[k]] = 1'b1;
               nq.push_back(q[k] + 1);
               lim = q[k] + 1;
            end else begin
               nq.push_back(q[k]);
               lim = q[k];
            end
         end
      end
      e.rdy = !mp && lim > 0;
      acc = v && e.rdy && (c || r);
      if (acc) nq.push_back(0);
      e.rr = q.size() > 0 && q[0] == S-1;
      e.push = acc && c;
      e.pop = acc && r;
      e.din = pc + (rvc ? W'(1) : W'(2));
      e.pv = m_pv;
      e.pt = m_pt;
      e.sm = m_sm;
      e.su = m_su;
      sb.push_back(e);
      @(posedge clk);
`ifdef RAS_CTRL_STATS_EN
      if (mp && q.size() > 0 && m_sm != '1) m_sm++;
      if (acc && r && !dv && m_su != '1) m_su++;
`endif
      q = nq;
      m_pv = acc && r && dv;
      if (acc && r) m_pt = dout;
   endtask
   initial begin
      step(0, 0, 0, '0, 0, 0, 0, '0, 0);
      step(0, 0, 0, '0, 0, 0, 0, '0, 0);
      #2 rst_ni = 1'b1;
      step(1, 1, 0, W'('h100), 0, 0, 0, '0, 0);
      step(1, 1, 0, W'('h200), 0, 0, 0, '0, 0);
      step(1, 1, 0, W'('h300), 0, 0, 0, '0, 0);
      step(1, 1, 0, W'('h300), 1, 1, 0, '0, 0);
      step(1, 0, 1, W'('h400), 0, 1, 0, W'('h2A0), 1);
      step(0, 0, 0, '0, 0, 0, 0, '0, 0);
      step(1, 1, 0, W'('h500), 0, 1, 1, '0, 0);
      step(1, 1, 0, W'('h7FFFFFFF), 1, 0, 0, '0, 0);
      step(1, 0, 1, W'('h600), 0, 0, 0, W'('h123), 0);
      step(0, 0, 0, '0, 0, 0, 0, '0, 0);
      step(0, 0, 0, '0, 0, 0, 1, '0, 0);
      step(1, 1, 0, W'('h700), 0, 0, 0, '0, 0);
      step(1, 1, 0, W'('h800), 1, 0, 0, '0, 0);
      #2;
      chk("pre_reset_occ_top", 64'(be_retire_ready_o), 64'(1));
      fe_valid_i = 1'b0;
      be_mispredict_i = 1'b1;
      be_retire_valid_i = 1'b1;
      rst_ni = 1'b0;
      #1;
      chk("reset_retire_ready", 64'(be_retire_ready_o), 64'(0));
      chk("reset_flush", 64'(ras_flush_o), 64'(0));
      chk("reset_commit", 64'(ras_commit_o), 64'(0));
      be_mispredict_i = 1'b0;
      #1;
      chk("reset_fe_ready", 64'(fe_ready_o), 64'(1));
      chk("reset_pred_valid", 64'(pred_valid_o), 64'(0));
      chk("reset_pred_target", 64'(pred_target_o), 64'(0));
      q = {};
      m_pv = 1'b0;
      m_pt = '0;
      m_sm = '0;
      m_su = '0;
      @(negedge clk);
      be_retire_valid_i = 1'b0;
      rst_ni = 1'b1;
      step(0, 0, 0, '0, 0, 0, 1, '0, 0);
      for (int i = 0; i < 500; i++)
         step($urandom % 4 != 0, $urandom % 2 == 1, $urandom % 2 == 1, W'($urandom), $urandom % 2 == 1,
              $urandom % 2 == 1, $urandom % 16 == 0, W'($urandom), $urandom % 4 != 0);
      @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
